// File: rtl/wb_pwm_pkg.sv
// rtl/wb_pwm_pkg.sv - register map, CTRL bit positions and defaults for wb_pwm
package wb_pwm_pkg;

    localparam int CNT_W_DEFAULT  = 16;
    localparam int CH_NUM_DEFAULT = 4;

    localparam logic [2:0] REG_CTRL     = 3'd0;
    localparam logic [2:0] REG_PRESCALE = 3'd1;
    localparam logic [2:0] REG_PERIOD   = 3'd2;
    localparam logic [2:0] REG_STATUS   = 3'd3;
    localparam logic [2:0] REG_DUTY0    = 3'd4;
    localparam logic [2:0] REG_DUTY1    = 3'd5;
    localparam logic [2:0] REG_DUTY2    = 3'd6;
    localparam logic [2:0] REG_DUTY3    = 3'd7;

    localparam int CTRL_EN        = 0;
    localparam int CTRL_IRQ_EN    = 1;
    localparam int CTRL_CH_EN_LSB = 4;
    localparam int CTRL_INV_LSB   = 8;
    localparam logic [31:0] CTRL_MASK = 32'h0000_0FF3;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  sel);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) r[8*b +: 8] = new_v[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_pwm_if.sv
// rtl/wb_pwm_if.sv - Wishbone slave bus bundle for wb_pwm
interface wb_pwm_if;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_i;
    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic        wb_we_i;
    logic        wb_ack_o;

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_we_i,
        output wb_dat_o, wb_ack_o
    );

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_we_i,
        input  wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/wb_pwm_channel.sv
// rtl/wb_pwm_channel.sv - one PWM output: compare against shadow duty, invert, register
module wb_pwm_channel
    import wb_pwm_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] counter_i,
    input  logic [CNT_W-1:0] duty_sh_i,
    input  logic             ch_en_i,
    input  logic             en_i,
    input  logic             invert_i,
    output logic             pwm_o
);

    logic pwm_q, pwm_d;

    // A disabled channel idles at its invert level
    always_comb begin
        pwm_d = (ch_en_i & en_i & (counter_i < duty_sh_i)) ^ invert_i;
    end

    always_ff @(posedge clk) begin
        if (reset) pwm_q <= 1'b0;
        else       pwm_q <= pwm_d;
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/wb_pwm.sv
// rtl/wb_pwm.sv - Wishbone PWM generator top: register file, prescaler, period counter
module wb_pwm
    import wb_pwm_pkg::*;
#(
    parameter int CH_NUM = CH_NUM_DEFAULT,
    parameter int CNT_W  = CNT_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    wb_pwm_if.slave           bus,
    output logic              intr,
    output logic [CH_NUM-1:0] pwm_o
);

    logic [31:0]      ctrl_q, ctrl_d;
    logic [CNT_W-1:0] prescale_q, prescale_d, period_q, period_d;
    logic [CNT_W-1:0] duty_q [CH_NUM];
    logic [CNT_W-1:0] duty_d [CH_NUM];
    logic [CNT_W-1:0] period_sh_q, period_sh_d;
    logic [CNT_W-1:0] duty_sh_q [CH_NUM];
    logic [CNT_W-1:0] duty_sh_d [CH_NUM];
    logic [CNT_W-1:0] presc_q, presc_d, cnt_q, cnt_d;
    logic             flag_q, flag_d, ack_q, ack_d, intr_q, intr_d;
    logic [31:0]      dat_q, dat_d, rdata;
    logic [2:0]       adr;
    logic             access, wr, en, tick, wrap;
    logic             unused_adr;

    assign adr        = bus.wb_adr_i[4:2];
    assign unused_adr = ^{bus.wb_adr_i[31:5], bus.wb_adr_i[1:0]};
    assign access     = bus.wb_cyc_i & bus.wb_stb_i & ~ack_q;
    assign wr         = access & bus.wb_we_i;
    assign en         = ctrl_q[CTRL_EN];
    // >= keeps a PRESCALE lowered mid-count from running to overflow
    assign tick       = en && (presc_q >= prescale_q);
    assign wrap       = tick && (cnt_q == period_sh_q);

    always_comb begin
        ctrl_d     = ctrl_q;
        prescale_d = prescale_q;
        period_d   = period_q;
        duty_d     = duty_q;
        flag_d     = flag_q;
        if (wr) begin
            case (adr)
                REG_CTRL:     ctrl_d = byte_merge(ctrl_q, bus.wb_dat_i, bus.wb_sel_i) & CTRL_MASK;
                REG_PRESCALE: prescale_d = CNT_W'(byte_merge(32'(prescale_q), bus.wb_dat_i, bus.wb_sel_i));
                REG_PERIOD:   period_d = CNT_W'(byte_merge(32'(period_q), bus.wb_dat_i, bus.wb_sel_i));
                REG_STATUS:   if (bus.wb_sel_i[0] & bus.wb_dat_i[0]) flag_d = 1'b0;
                default:      duty_d[adr[1:0]] = CNT_W'(byte_merge(32'(duty_q[adr[1:0]]),
                                                                   bus.wb_dat_i, bus.wb_sel_i));
            endcase
        end
        // A hardware wrap beats a simultaneous software clear
        if (wrap) flag_d = 1'b1;
    end

    always_comb begin
        presc_d     = presc_q;
        cnt_d       = cnt_q;
        period_sh_d = period_sh_q;
        duty_sh_d   = duty_sh_q;
        if (!en) begin
            presc_d     = '0;
            cnt_d       = '0;
            period_sh_d = period_q;
            duty_sh_d   = duty_q;
        end else begin
            presc_d = tick ? '0 : presc_q + CNT_W'(1);
            if (wrap) begin
                cnt_d       = '0;
                period_sh_d = period_q;
                duty_sh_d   = duty_q;
            end else if (tick) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (adr)
            REG_CTRL:     rdata = ctrl_q;
            REG_PRESCALE: rdata = 32'(prescale_q);
            REG_PERIOD:   rdata = 32'(period_q);
            REG_STATUS:   rdata = {16'(cnt_q), 15'd0, flag_q};
            default:      rdata = 32'(duty_q[adr[1:0]]);
        endcase
        dat_d  = access ? rdata : dat_q;
        ack_d  = access;
        intr_d = flag_q & ctrl_q[CTRL_IRQ_EN];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q      <= '0;
            prescale_q  <= '0;
            period_q    <= '0;
            duty_q      <= '{default: '0};
            period_sh_q <= '0;
            duty_sh_q   <= '{default: '0};
            presc_q     <= '0;
            cnt_q       <= '0;
            flag_q      <= 1'b0;
            ack_q       <= 1'b0;
            dat_q       <= '0;
            intr_q      <= 1'b0;
        end else begin
            ctrl_q      <= ctrl_d;
            prescale_q  <= prescale_d;
            period_q    <= period_d;
            duty_q      <= duty_d;
            period_sh_q <= period_sh_d;
            duty_sh_q   <= duty_sh_d;
            presc_q     <= presc_d;
            cnt_q       <= cnt_d;
            flag_q      <= flag_d;
            ack_q       <= ack_d;
            dat_q       <= dat_d;
            intr_q      <= intr_d;
        end
    end

    for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
        wb_pwm_channel #(.CNT_W(CNT_W)) u_ch (
            .clk       (clk),
            .reset     (reset),
            .counter_i (cnt_q),
            .duty_sh_i (duty_sh_q[i]),
            .ch_en_i   (ctrl_q[CTRL_CH_EN_LSB + i]),
            .en_i      (en),
            .invert_i  (ctrl_q[CTRL_INV_LSB + i]),
            .pwm_o     (pwm_o[i])
        );
    end

    assign bus.wb_ack_o = ack_q;
    assign bus.wb_dat_o = dat_q;
    assign intr         = intr_q;

endmodule
